// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for a shared combinational ALU.
// Each accepted operation takes three cycles: IDLE (accept) -> EXEC -> DONE.
// Ports:
//   clk, rst               clock, async active-high reset
//   valid0/1, a0/1, b0/1,  per-requester request, operands and function code
//   func0/1
//   ready0/1               request accepted this cycle (IDLE only)
//   done0/1                one-cycle pulse in DONE for the granted requester
//   result                 last captured ALU result, held between completions
//   alu_a/alu_b/alu_func   drive the shared ALU (always the operand registers)
//   alu_c                  ALU result, same cycle as alu_a/alu_b/alu_func
//   busy                   high whenever not in IDLE
module alu_arbiter #(
  parameter int DATA_W = 8,
  parameter int FUNC_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid0,
  input  logic              valid1,
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] b0,
  input  logic [DATA_W-1:0] b1,
  input  logic [FUNC_W-1:0] func0,
  input  logic [FUNC_W-1:0] func1,
  output logic              ready0,
  output logic              ready1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [FUNC_W-1:0] alu_func,
  input  logic [DATA_W-1:0] alu_c,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

  state_e            state_q, state_d;
  logic              ptr_q, ptr_d;   // preferred requester on a tie
  logic              gnt_q, gnt_d;   // requester owning the operation in flight
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [FUNC_W-1:0] func_q, func_d;
  logic              sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      gnt_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      func_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      func_q   <= func_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    a_d      = a_q;
    b_d      = b_q;
    func_d   = func_q;
    result_d = result_q;
    ready0   = 1'b0;
    ready1   = 1'b0;
    sel      = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid0 || valid1) begin
          // Tie goes to the pointer; a lone request wins regardless.
          sel     = (valid0 && valid1) ? ptr_q : valid1;
          // rst gating keeps ready low while reset is held with valids up,
          // so no acceptance happens before the first edge with rst low.
          ready0  = ~sel & ~rst;
          ready1  = sel & ~rst;
          gnt_d   = sel;
          ptr_d   = ~sel;
          a_d     = sel ? a1 : a0;
          b_d     = sel ? b1 : b0;
          func_d  = sel ? func1 : func0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d = alu_c;
        state_d  = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign done0    = (state_q == DONE) && !gnt_q;
  assign done1    = (state_q == DONE) &&  gnt_q;
  assign busy     = (state_q != IDLE);
  assign result   = result_q;
  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_func = func_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small combinational ALU model.
module tb_alu_arbiter;
  localparam int DW = 8;
  localparam int FW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid0 = 0, valid1 = 0;
  logic [DW-1:0] a0 = 0, a1 = 0, b0 = 0, b1 = 0;
  logic [FW-1:0] func0 = 0, func1 = 0;
  logic          ready0, ready1, done0, done1, busy;
  logic [DW-1:0] result, alu_a, alu_b, alu_c;
  logic [FW-1:0] alu_func;

  int npass = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(DW), .FUNC_W(FW)) dut (
    .clk(clk), .rst(rst),
    .valid0(valid0), .valid1(valid1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .func0(func0), .func1(func1),
    .ready0(ready0), .ready1(ready1),
    .done0(done0), .done1(done1),
    .result(result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
    .alu_c(alu_c), .busy(busy)
  );

  // ALU model: 0 add, 1 sub, 2 and, 3 or, 4 xor, otherwise pass a.
  always_comb begin
    alu_c = alu_a;
    case (alu_func)
      3'd0: alu_c = alu_a + alu_b;
      3'd1: alu_c = alu_a - alu_b;
      3'd2: alu_c = alu_a & alu_b;
      3'd3: alu_c = alu_a | alu_b;
      3'd4: alu_c = alu_a ^ alu_b;
      default: alu_c = alu_a;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    assert (got === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_ready0", ready0, 0);
    chk("rst_ready1", ready1, 0);
    chk("rst_done", {done0, done1}, 0);
    chk("rst_result", result, 0);
    chk("rst_alu", {alu_a, alu_b, alu_func}, 0);
    rst = 0;

    // Single request: 10 + 3
    valid0 = 1; a0 = 10; b0 = 3; func0 = 0;
    #1;
    chk("s_ready0", ready0, 1);
    chk("s_ready1", ready1, 0);
    chk("s_busy_idle", busy, 0);
    tick(); valid0 = 0;
    chk("s_alu_a", alu_a, 10);
    chk("s_alu_b", alu_b, 3);
    chk("s_alu_func", alu_func, 0);
    chk("s_busy_exec", busy, 1);
    chk("s_ready_exec", {ready0, ready1}, 0);
    tick();
    chk("s_done0", done0, 1);
    chk("s_done1", done1, 0);
    chk("s_result", result, 13);
    tick();
    chk("s_done_clr", {done0, done1}, 0);
    chk("s_result_hold", result, 13);

    // Reset back to pointer 0, then simultaneous requests
    rst = 1; #1;
    chk("r_result0", result, 0);
    tick(); rst = 0;
    valid0 = 1; a0 = 4;  b0 = 2; func0 = 1;
    valid1 = 1; a1 = 10; b1 = 3; func1 = 0;
    #1;
    chk("m_ready0", ready0, 1);
    chk("m_ready1_n", ready1, 0);
    tick(); valid0 = 0;
    chk("m_ready1_exec", ready1, 0);
    tick();
    chk("m_done0", done0, 1);
    chk("m_result0", result, 2);
    chk("m_ready1_done", ready1, 0);
    tick();
    chk("m_ready1", ready1, 1);
    chk("m_ready0_n", ready0, 0);
    tick(); valid1 = 0;
    chk("m_alu_a1", alu_a, 10);
    tick();
    chk("m_done1", done1, 1);
    chk("m_done0_n", done0, 0);
    chk("m_result1", result, 13);
    tick();

    // Fairness: both held for 12 cycles; pointer is back at 0
    valid0 = 1; a0 = 1; b0 = 1; func0 = 0;
    valid1 = 1; a1 = 5; b1 = 2; func1 = 1;
    for (int i = 0; i < 12; i++) begin
      #1;
      chk($sformatf("f_ready0_%0d", i), ready0, (i % 6) == 0);
      chk($sformatf("f_ready1_%0d", i), ready1, (i % 6) == 3);
      chk($sformatf("f_done0_%0d", i), done0, (i % 6) == 2);
      chk($sformatf("f_done1_%0d", i), done1, (i % 6) == 5);
      if (i % 3 == 2) chk($sformatf("f_res_%0d", i), result, (i % 6) == 2 ? 2 : 3);
      tick();
    end
    valid0 = 0; valid1 = 0;

    // Stability: operand changes after ready do not leak in
    valid0 = 1; a0 = 20; b0 = 5; func0 = 0;
    #1;
    chk("st_ready0", ready0, 1);
    tick(); valid0 = 0; a0 = 255;
    #1;
    chk("st_alu_a", alu_a, 20);
    tick();
    chk("st_done0", done0, 1);
    chk("st_result", result, 25);
    tick();
    chk("st_result_idle", result, 25);

    // Idle for 10 cycles
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("i_flags_%0d", i), {busy, ready0, ready1, done0, done1}, 0);
      chk($sformatf("i_result_%0d", i), result, 25);
    end

    // Reset in EXEC (pointer now 1)
    valid1 = 1; a1 = 7; b1 = 1; func1 = 0;
    #1;
    chk("x_ready1", ready1, 1);
    tick(); valid1 = 0;
    chk("x_busy", busy, 1);
    #2; rst = 1; #1;
    chk("x_busy0", busy, 0);
    chk("x_result0", result, 0);
    chk("x_alu0", {alu_a, alu_b, alu_func}, 0);
    chk("x_done0", {done0, done1}, 0);
    valid0 = 1; a0 = 9; b0 = 9; func0 = 6;
    valid1 = 1;
    #1;
    chk("x_ready_in_rst", {ready0, ready1}, 0);
    tick();
    chk("x_done_in_rst", {done0, done1}, 0);
    rst = 0; #1;
    chk("x_rearb_ready0", ready0, 1);
    chk("x_rearb_ready1", ready1, 0);
    tick(); valid0 = 0; valid1 = 0;
    chk("x_func_pass", alu_func, 6);
    tick();
    chk("x_done0_after", done0, 1);
    chk("x_result_pass", result, 9);
    tick();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
